// File: rtl/dht11_reader.sv
// dht11_reader: single-wire protocol controller for the DHT11 sensor.
// Issues the host start pulse, times the sensor's response and 40 data bits,
// verifies the frame and presents humidity/temperature bytes with a
// done/error strobe. Feeds the tristate pad stage (o_Dir/o_Send, i_Read).
//
// Optional feature macro: DHT11_CHECKSUM_EN
//   defined   - the fifth byte is compared against the 8-bit sum of the
//               four data bytes; a mismatch ends the transaction in error.
//   undefined - the checksum byte is shifted in but ignored; errors come
//               from timeouts only.
module dht11_reader #(
   parameter int START_LOW_CYC  = 900000,
   parameter int BIT_THRESH_CYC = 2500,
   parameter int TIMEOUT_CYC    = 5000,
   parameter int CNT_W          = 20
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Start,
   input  logic       i_Read,
   output logic       o_Dir,
   output logic       o_Send,
   output logic       o_Busy,
   output logic       o_Done,
   output logic       o_Error,
   output logic [7:0] o_Humid_Int,
   output logic [7:0] o_Humid_Dec,
   output logic [7:0] o_Temp_Int,
   output logic [7:0] o_Temp_Dec
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START_LOW,
      S_WAIT_RESP,
      S_RESP_LOW,
      S_RESP_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_CHECK,
      S_DONE,
      S_FAIL
   } t_state;

   // Last count value of the host start pulse (counter starts at 0 on entry).
   localparam logic [CNT_W-1:0] C_START_END = CNT_W'(START_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] C_THRESH    = CNT_W'(BIT_THRESH_CYC);
   localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT_CYC);
   localparam logic [5:0]       C_LAST_BIT  = 6'd39;

   t_state           r_State;
   t_state           w_State_Next;
   logic [CNT_W-1:0] r_Cnt;
   logic [1:0]       r_Sync;
   logic             r_Line_d;
   logic             w_Rise;
   logic             w_Fall;
   logic             w_Timeout;
   logic             w_Bit_Val;
   logic             w_Sum_Ok;
   logic             w_Accept;
   logic [39:0]      r_Shift;
   logic [5:0]       r_Bit_Idx;
   logic             r_Dir;
   logic             r_Busy;
   logic             r_Done;
   logic             r_Error;
   logic [7:0]       r_Humid_Int;
   logic [7:0]       r_Humid_Dec;
   logic [7:0]       r_Temp_Int;
   logic [7:0]       r_Temp_Dec;

   // Two-flop synchronizer plus one delayed copy for edge detection.
   // Idle line level is high (pull-up), so the flops reset to 1.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Sync   <= 2'b11;
         r_Line_d <= 1'b1;
      end else begin
         r_Sync   <= {r_Sync[0], i_Read};
         r_Line_d <= r_Sync[1];
      end
   end

   assign w_Rise    = r_Sync[1] & ~r_Line_d;
   assign w_Fall    = ~r_Sync[1] & r_Line_d;
   assign w_Timeout = (r_Cnt >= C_TIMEOUT);
   assign w_Accept  = (r_State == S_IDLE) && i_Start;

   // The counter is cleared in the cycle after the rising edge is seen, so at
   // the falling edge it holds (high length - 1). Comparing with >= therefore
   // makes a high phase of exactly BIT_THRESH_CYC cycles a 0, one more a 1.
   assign w_Bit_Val = (r_Cnt >= C_THRESH);

`ifdef DHT11_CHECKSUM_EN
   logic [7:0] w_Sum;
   assign w_Sum    = r_Shift[39:32] + r_Shift[31:24] + r_Shift[23:16] + r_Shift[15:8];
   assign w_Sum_Ok = (w_Sum == r_Shift[7:0]);
`else
   assign w_Sum_Ok = 1'b1;
`endif

   // State register; reset returns to IDLE at once, releasing the line.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State <= S_IDLE;
      end else begin
         r_State <= w_State_Next;
      end
   end

   // Next-state logic: edge-driven protocol walk with per-phase timeout.
   always_comb begin
      w_State_Next = r_State;
      case (r_State)
         S_IDLE: begin
            if (i_Start) w_State_Next = S_START_LOW;
         end
         S_START_LOW: begin
            if (r_Cnt >= C_START_END) w_State_Next = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (w_Fall)         w_State_Next = S_RESP_LOW;
            else if (w_Timeout) w_State_Next = S_FAIL;
         end
         S_RESP_LOW: begin
            if (w_Rise)         w_State_Next = S_RESP_HIGH;
            else if (w_Timeout) w_State_Next = S_FAIL;
         end
         S_RESP_HIGH: begin
            if (w_Fall)         w_State_Next = S_BIT_LOW;
            else if (w_Timeout) w_State_Next = S_FAIL;
         end
         S_BIT_LOW: begin
            if (w_Rise)         w_State_Next = S_BIT_HIGH;
            else if (w_Timeout) w_State_Next = S_FAIL;
         end
         S_BIT_HIGH: begin
            if (w_Fall)         w_State_Next = (r_Bit_Idx == C_LAST_BIT) ? S_CHECK : S_BIT_LOW;
            else if (w_Timeout) w_State_Next = S_FAIL;
         end
         S_CHECK: begin
            w_State_Next = w_Sum_Ok ? S_DONE : S_FAIL;
         end
         S_DONE:  w_State_Next = S_IDLE;
         S_FAIL:  w_State_Next = S_IDLE;
         default: w_State_Next = S_IDLE;
      endcase
   end

   // Phase counter: restarts on every state change, saturates at all-ones.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Cnt <= '0;
      end else if (w_State_Next != r_State) begin
         r_Cnt <= '0;
      end else if (r_Cnt != '1) begin
         r_Cnt <= r_Cnt + CNT_W'(1);
      end
   end

   // Frame capture: MSB-first shift on each falling edge that ends a bit.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Shift   <= '0;
         r_Bit_Idx <= '0;
      end else if (w_Accept) begin
         r_Bit_Idx <= '0;
      end else if ((r_State == S_BIT_HIGH) && w_Fall) begin
         r_Shift   <= {r_Shift[38:0], w_Bit_Val};
         r_Bit_Idx <= r_Bit_Idx + 6'd1;
      end
   end

   // Registered control outputs, decoded from the next state so they line up
   // with the state they describe and never glitch toward the pad.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Dir  <= 1'b0;
         r_Busy <= 1'b0;
         r_Done <= 1'b0;
      end else begin
         r_Dir  <= (w_State_Next == S_START_LOW);
         r_Busy <= (w_State_Next inside {S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
                                         S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK});
         r_Done <= (w_State_Next inside {S_DONE, S_FAIL});
      end
   end

   // Error flag: cleared by an accepted start, set on entry to FAIL, sticky.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Error <= 1'b0;
      end else if (w_Accept) begin
         r_Error <= 1'b0;
      end else if ((w_State_Next == S_FAIL) && (r_State != S_FAIL)) begin
         r_Error <= 1'b1;
      end
   end

   // Data bytes update only on a verified frame; failures leave them as-is.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Humid_Int <= '0;
         r_Humid_Dec <= '0;
         r_Temp_Int  <= '0;
         r_Temp_Dec  <= '0;
      end else if ((r_State == S_CHECK) && (w_State_Next == S_DONE)) begin
         r_Humid_Int <= r_Shift[39:32];
         r_Humid_Dec <= r_Shift[31:24];
         r_Temp_Int  <= r_Shift[23:16];
         r_Temp_Dec  <= r_Shift[15:8];
      end
   end

   // The controller only ever pulls low or releases; it never drives high.
   assign o_Send      = 1'b0;
   assign o_Dir       = r_Dir;
   assign o_Busy      = r_Busy;
   assign o_Done      = r_Done;
   assign o_Error     = r_Error;
   assign o_Humid_Int = r_Humid_Int;
   assign o_Humid_Dec = r_Humid_Dec;
   assign o_Temp_Int  = r_Temp_Int;
   assign o_Temp_Dec  = r_Temp_Dec;

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Single-wire protocol controller for the DHT11 temperature/humidity sensor.
- Sits directly upstream of the tristate pad stage: drives its direction and send inputs, and consumes its read output.
- On a start request, issues the host start pulse, captures the sensor's 40-bit frame and verifies it.
- Presents humidity and temperature bytes to the display/interface logic with a done/error strobe.

Parameters:
- START_LOW_CYC, 900000, host start-pulse low duration in clock cycles (18 ms @ 50 MHz).
- BIT_THRESH_CYC, 2500, high-phase length above which a data bit reads as 1 (50 us @ 50 MHz).
- TIMEOUT_CYC, 5000, maximum cycles any single wait phase may last before abort (100 us @ 50 MHz).
- CNT_W, 20, phase counter width; must hold max(START_LOW_CYC, TIMEOUT_CYC).

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  one-cycle request to begin a measurement.
- i_Read  input  1  line level from pad stage (asynchronous to i_Clk).
- o_Dir  output  1  1 = drive line, 0 = release (pull-up / sensor owns line).
- o_Send  output  1  level driven when o_Dir=1.
- o_Busy  output  1  high from accepted start until o_Done.
- o_Done  output  1  one-cycle strobe at end of every transaction, success or failure.
- o_Error  output  1  valid with o_Done; sticky until next accepted start.
- o_Humid_Int  output  8  humidity integer byte.
- o_Humid_Dec  output  8  humidity decimal byte.
- o_Temp_Int  output  8  temperature integer byte.
- o_Temp_Dec  output  8  temperature decimal byte.

Behaviour:
- Clock and reset: one clock i_Clk; i_Rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; line released (o_Dir=0) immediately on reset assertion, including mid-transaction.
- Input sync: i_Read passes through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized value. This adds 2 cycles of latency, which are ignored in the counts.
- Line ownership: o_Send is constant 0. o_Dir=1 only in START_LOW; all other states release the line.
- Phase counter: cleared on every state transition, increments each cycle, saturates at all-ones.
- IDLE: i_Start -> START_LOW, o_Busy=1, o_Error=0, bit index=0. i_Start in any other state is ignored.
- START_LOW: hold for START_LOW_CYC cycles -> WAIT_RESP.
- WAIT_RESP: line released. Falling edge -> RESP_LOW.
- RESP_LOW: rising edge -> RESP_HIGH.
- RESP_HIGH: falling edge -> BIT_LOW.
- BIT_LOW: rising edge -> BIT_HIGH.
- BIT_HIGH: on falling edge, shift in bit = (counter > BIT_THRESH_CYC), MSB first, into the 40-bit shift register. Count exactly BIT_THRESH_CYC gives 0; BIT_THRESH_CYC+1 gives 1. Then:
  - after 40th bit -> CHECK;
  - otherwise -> BIT_LOW.
- Timeout: in any wait state (WAIT_RESP..BIT_HIGH), counter reaching TIMEOUT_CYC -> FAIL.
- CHECK: frame = H_int, H_dec, T_int, T_dec, CS. Pass if (H_int+H_dec+T_int+T_dec) mod 256 == CS (8-bit wrap). Pass -> DONE; fail -> FAIL.
- DONE: latch the four data bytes to outputs; o_Done=1 for one cycle; o_Busy=0 -> IDLE.
- FAIL: data outputs hold previous values; o_Error=1, o_Done=1 for one cycle; o_Busy=0 -> IDLE.
- The sensor's trailing 50 us low after bit 40 is not waited on. A new start is accepted the cycle after o_Done.

Optional Feature:
- Macro: DHT11_CHECKSUM_EN.
- Defined: CHECK compares the checksum as above.
- Undefined: CHECK always passes; the checksum byte is shifted in but discarded. o_Error is then raised by timeout only.

Test Plan:
- Bench parameters: START_LOW_CYC=100, BIT_THRESH_CYC=20, TIMEOUT_CYC=50; sensor model uses bit high 10 cycles (0) and 35 cycles (1).
- Reset: assert i_Rst_n=0 mid START_LOW -> o_Dir drops to 0 without a clock edge; after release all outputs 0, state IDLE.
- Good frame: i_Start; model returns 0x37,0x00,0x19,0x00,0x50 -> o_Dir=1 for exactly 100 cycles; o_Humid_Int=0x37, o_Temp_Int=0x19, decimals 0x00; o_Done one cycle; o_Error=0.
- Bad checksum: model sends CS=0x51 -> o_Done with o_Error=1; data outputs keep 0x37/0x19 from the prior frame. With DHT11_CHECKSUM_EN undefined -> o_Error=0 and data updates.
- Checksum wrap: bytes 0xFF,0x01,0x80,0x80 with CS=0x00 -> pass, no error.
- No response: line held high after release -> FAIL 50 cycles after entering WAIT_RESP; o_Error=1, o_Busy=0.
- Threshold/boundary: bit high exactly 20 cycles -> 0, 21 cycles -> 1. A second i_Start pulse during BIT_LOW is ignored, so exactly one o_Done results.
